gray_monitor: RTL and testbench

Downstream checker for the 3-bit Gray counter stage. Samples the counter's Output, Overflow and the counter's own Reset/En controls every cycle. Converts Gray to binary, pulses on each legal step and wrap, and counts wraps. Flags any illegal code sequence, overflow misuse or enable mismatch with a sticky error and cause code. Sits between the counter and the downstream logic and status registers.

---
 rtl/gray_monitor.sv | 176 +++++++++++++++++
 tb/tb_gray_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_monitor.sv
// Downstream checker for a 3-bit Gray counter. It tracks each code step, pulses
// on legal advances and wraps, counts wraps, and latches the first fault seen.
module gray_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CntReset,
    input  logic              CntEn,
    input  logic [2:0]        Gray,
    input  logic              Overflow,
    input  logic              ErrClr,
    output logic [2:0]        Bin,
    output logic              Step,
    output logic              Wrap,
    output logic [WRAP_W-1:0] WrapCount,
    output logic              Error,
    output logic [1:0]        ErrCode
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CODE = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_EN   = 2'b11
    } err_e;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    state_e            state_q, state_d;
    err_e              err_code_q, err_code_d;
    logic              error_q, error_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [2:0]        bin_q;
    logic [2:0]        prev_gray_q;
    logic              prev_ovf_q;
    logic              en_d_q;
    logic              rst_d_q;

    logic [2:0]        gray_next;
    logic              advance;
    logic              hold;
    logic              code_err;
    logic              en_err;
    logic              ovf_err;

    // The counter reacts to En/Reset one edge before its result reaches us, so
    // the current sample is judged against the delayed controls.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        gray_next = bin2gray(gray2bin(prev_gray_q) + 3'd1);
        advance   = 1'b0;
        hold      = 1'b0;
        code_err  = 1'b0;
        en_err    = 1'b0;
        ovf_err   = 1'b0;

        if (rst_d_q) begin
            code_err = (Gray != 3'b000) || Overflow;
        end else if (en_d_q) begin
            if (Gray == gray_next)        advance  = 1'b1;
            else if (Gray == prev_gray_q) en_err   = 1'b1;
            else                          code_err = 1'b1;
        end else begin
            if (Gray == prev_gray_q)      hold     = 1'b1;
            else if (Gray == gray_next)   en_err   = 1'b1;
            else                          code_err = 1'b1;
        end

        if (advance && (prev_gray_q == 3'b100)) begin
            ovf_err = !Overflow;
        end else if (advance || hold) begin
            ovf_err = (Overflow != prev_ovf_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        wrap_cnt_d = wrap_cnt_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_TRACK;
            end

            ST_TRACK: begin
                if (rst_d_q) begin
                    wrap_cnt_d = '0;
                    state_d    = ST_INIT;
                end

                if (code_err || en_err || ovf_err) begin
                    error_d    = 1'b1;
                    err_code_d = code_err ? ERR_CODE : (en_err ? ERR_EN : ERR_OVF);
                    state_d    = ST_FAULT;
                end else if (advance) begin
                    step_d = 1'b1;
                    if (prev_gray_q == 3'b100) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                    end
                end
            end

            ST_FAULT: begin
                // First fault stays latched until software acknowledges it.
                if (ErrClr) begin
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_INIT;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_INIT;
            err_code_q  <= ERR_NONE;
            error_q     <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_cnt_q  <= '0;
            bin_q       <= 3'b000;
            prev_gray_q <= 3'b000;
            prev_ovf_q  <= 1'b0;
            en_d_q      <= 1'b0;
            rst_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            error_q     <= error_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            wrap_cnt_q  <= wrap_cnt_d;
            bin_q       <= gray2bin(Gray);
            prev_gray_q <= Gray;
            prev_ovf_q  <= Overflow;
            en_d_q      <= CntEn;
            rst_d_q     <= CntReset;
        end
    end

    assign Bin       = bin_q;
    assign Step      = step_q;
    assign Wrap      = wrap_q;
    assign WrapCount = wrap_cnt_q;
    assign Error     = error_q;
    assign ErrCode   = err_code_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: directed vector table, hand-written
// corner sequences, and random counter-like traffic against a sequence model.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CntReset = 1'b0;
    logic       CntEn = 1'b0;
    logic [2:0] Gray = 3'b000;
    logic       Overflow = 1'b0;
    logic       ErrClr = 1'b0;

    logic [2:0] bin8, bin2;
    logic       step8, step2, wrap8, wrap2, err8, err2;
    logic [7:0] wcnt8;
    logic [1:0] wcnt2;
    logic [1:0] code8, code2;

    int total = 0;
    int bad   = 0;

    gray_monitor #(.WRAP_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .CntReset(CntReset), .CntEn(CntEn),
        .Gray(Gray), .Overflow(Overflow), .ErrClr(ErrClr),
        .Bin(bin8), .Step(step8), .Wrap(wrap8), .WrapCount(wcnt8),
        .Error(err8), .ErrCode(code8)
    );

    gray_monitor #(.WRAP_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .CntReset(CntReset), .CntEn(CntEn),
        .Gray(Gray), .Overflow(Overflow), .ErrClr(ErrClr),
        .Bin(bin2), .Step(step2), .Wrap(wrap2), .WrapCount(wcnt2),
        .Error(err2), .ErrCode(code2)
    );

    always #5 Clk = ~Clk;

    // Counting order of the 3-bit Gray code; the index is the binary value.
    function automatic logic [2:0] seq_at(input int i);
        case (i % 8)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b111;
            6: return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int pos_of(input logic [2:0] g);
        for (int i = 0; i < 8; i++) if (seq_at(i) == g) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position-in-sequence arithmetic plus a mode flag.
    typedef enum int {M_INIT, M_TRACK, M_FAULT} mode_e;
    mode_e      m_mode;
    logic [2:0] m_prev;
    logic       m_prev_ovf, m_en, m_rst;
    int         m_bin, m_step, m_wrap, m_wcnt, m_err, m_code;

    task automatic model_reset();
        m_mode = M_INIT; m_prev = 3'b000; m_prev_ovf = 1'b0; m_en = 1'b0; m_rst = 1'b0;
        m_bin = 0; m_step = 0; m_wrap = 0; m_wcnt = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_step();
        int cur, prv, code;
        bit adv, hold;
        cur = pos_of(Gray);
        prv = pos_of(m_prev);
        code = 0;
        m_step = 0;
        m_wrap = 0;
        m_bin = cur;
        case (m_mode)
            M_INIT: m_mode = M_TRACK;
            M_TRACK: begin
                adv  = (cur == (prv + 1) % 8);
                hold = (cur == prv);
                if (m_rst) begin
                    m_wcnt = 0;
                    if (Gray != 3'b000 || Overflow) code = 1;
                    else m_mode = M_INIT;
                end else if (m_en && !adv) begin
                    code = hold ? 3 : 1;
                end else if (!m_en && !hold) begin
                    code = adv ? 3 : 1;
                end else if (adv && prv == 7) begin
                    if (!Overflow) code = 2;
                    else begin m_step = 1; m_wrap = 1; m_wcnt++; end
                end else if (Overflow != m_prev_ovf) begin
                    code = 2;
                end else if (adv) begin
                    m_step = 1;
                end
                if (code != 0) begin m_err = 1; m_code = code; m_mode = M_FAULT; end
            end
            default: if (ErrClr) begin m_err = 0; m_code = 0; m_mode = M_INIT; end
        endcase
        m_prev = Gray; m_prev_ovf = Overflow; m_en = CntEn; m_rst = CntReset;
    endtask

    task automatic drive(input logic rst, input logic en, input logic [2:0] g,
                         input logic ovf, input logic clr);
        CntReset = rst; CntEn = en; Gray = g; Overflow = ovf; ErrClr = clr;
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_bin"},   bin8,  m_bin);
        check({tag, "_step"},  step8, m_step);
        check({tag, "_wrap"},  wrap8, m_wrap);
        check({tag, "_wcnt"},  wcnt8, m_wcnt % 256);
        check({tag, "_err"},   err8,  m_err);
        check({tag, "_code"},  code8, m_code);
        check({tag, "_wcnt2"}, wcnt2, m_wcnt % 4);
    endtask

    // Reset is raised between clock edges and outputs must clear at once.
    task automatic reset_dut();
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        CntReset = 1'b0; CntEn = 1'b0; Gray = 3'b000; Overflow = 1'b0; ErrClr = 1'b0;
        #1;
        check("rst_bin", bin8, 0);
        check("rst_step", step8, 0);
        check("rst_wrap", wrap8, 0);
        check("rst_wcnt", wcnt8, 0);
        check("rst_err", err8, 0);
        check("rst_code", code8, 0);
        check("rst_wcnt2", wcnt2, 0);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic       rst, en;
        logic [2:0] g;
        logic       ovf, clr;
        logic [2:0] bin;
        logic       step, wrap;
        int         wcnt;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[32];
    int   n_vec = 0;

    task automatic add_vec(input logic rst, en, input logic [2:0] g, input logic ovf, clr,
                           input logic [2:0] bin, input logic step, wrap, input int wcnt,
                           input logic err, input logic [1:0] code);
        tbl[n_vec] = '{rst, en, g, ovf, clr, bin, step, wrap, wcnt, err, code};
        n_vec++;
    endtask

    initial begin
        int   c_pos;
        logic c_ovf;
        logic r_rst, r_en, r_clr, r_ovf;
        logic [2:0] r_g;

        // Full legal cycle with one wrap, hold at 011, then an enable mismatch.
        add_vec(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b001, 0, 0, 1, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b011, 0, 0, 2, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b010, 0, 0, 3, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b110, 0, 0, 4, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b111, 0, 0, 5, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b101, 0, 0, 6, 1, 0, 0, 0, 2'b00);
        add_vec(0, 1, 3'b100, 0, 0, 7, 1, 0, 0, 0, 2'b00);
        add_vec(0, 0, 3'b000, 1, 0, 0, 1, 1, 1, 0, 2'b00);
        add_vec(0, 1, 3'b000, 1, 0, 0, 0, 0, 1, 0, 2'b00);
        add_vec(0, 1, 3'b001, 1, 0, 1, 1, 0, 1, 0, 2'b00);
        add_vec(0, 0, 3'b011, 1, 0, 2, 1, 0, 1, 0, 2'b00);
        for (int i = 0; i < 5; i++) add_vec(0, 0, 3'b011, 1, 0, 2, 0, 0, 1, 0, 2'b00);
        add_vec(0, 0, 3'b010, 1, 0, 3, 0, 0, 1, 1, 2'b11);
        add_vec(0, 0, 3'b010, 1, 1, 3, 0, 0, 1, 0, 2'b00);
        add_vec(0, 0, 3'b010, 1, 0, 3, 0, 0, 1, 0, 2'b00);
        add_vec(0, 0, 3'b010, 1, 0, 3, 0, 0, 1, 0, 2'b00);

        reset_dut();
        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].g, tbl[i].ovf, tbl[i].clr);
            check($sformatf("vec%0d_bin", i),  bin8,  tbl[i].bin);
            check($sformatf("vec%0d_step", i), step8, tbl[i].step);
            check($sformatf("vec%0d_wrap", i), wrap8, tbl[i].wrap);
            check($sformatf("vec%0d_wcnt", i), wcnt8, tbl[i].wcnt);
            check($sformatf("vec%0d_err", i),  err8,  tbl[i].err);
            check($sformatf("vec%0d_code", i), code8, tbl[i].code);
        end

        // Illegal jump 001->110, sticky code, clear, then tracking resumes.
        reset_dut();
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 1, 3'b001, 0, 0);
        drive(0, 1, 3'b110, 0, 0);
        check("jump_err", err8, 1);
        check("jump_code", code8, 2'b01);
        check("jump_step", step8, 0);
        drive(0, 1, 3'b000, 1, 0);
        check("sticky_code", code8, 2'b01);
        check("sticky_bin", bin8, 0);
        drive(0, 0, 3'b000, 0, 1);
        check("clr_err", err8, 0);
        check("clr_code", code8, 2'b00);
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 1, 3'b001, 0, 0);
        check("resume_step", step8, 1);
        check("resume_err", err8, 0);

        // Wrap without Overflow.
        reset_dut();
        for (int k = 0; k < 8; k++) drive(0, 1, seq_at(k), 0, 0);
        drive(0, 1, 3'b000, 0, 0);
        check("novf_code", code8, 2'b10);
        check("novf_wrap", wrap8, 0);
        check("novf_wcnt", wcnt8, 0);

        // Overflow rising on an ordinary step.
        reset_dut();
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 1, 3'b001, 0, 0);
        drive(0, 1, 3'b011, 1, 0);
        check("ovfstep_code", code8, 2'b10);
        check("ovfstep_step", step8, 0);

        // Three wraps then a clean counter reset.
        reset_dut();
        for (int k = 0; k < 24; k++) drive(0, 1, seq_at(k), k >= 8, 0);
        drive(1, 0, 3'b000, 1, 0);
        check("w3_wcnt", wcnt8, 3);
        check("w3_wrap", wrap8, 1);
        drive(0, 0, 3'b000, 0, 0);
        check("crst_wcnt", wcnt8, 0);
        check("crst_err", err8, 0);
        check("crst_step", step8, 0);
        drive(0, 0, 3'b000, 0, 0);
        drive(0, 0, 3'b000, 0, 0);
        check("crst_hold_err", err8, 0);

        // Counter reset whose next sample is not 000.
        reset_dut();
        for (int k = 0; k < 24; k++) drive(0, 1, seq_at(k), k >= 8, 0);
        drive(1, 0, 3'b000, 1, 0);
        drive(0, 0, 3'b001, 0, 0);
        check("crst_bad_err", err8, 1);
        check("crst_bad_code", code8, 2'b01);

        // Four wraps: the 2-bit counter rolls over.
        reset_dut();
        for (int k = 0; k < 34; k++) begin
            drive(0, 1, seq_at(k), k >= 8, 0);
            if (k > 0 && k % 8 == 0) begin
                check($sformatf("w2_wcnt_k%0d", k), wcnt2, (k / 8) % 4);
                check($sformatf("w8_wcnt_k%0d", k), wcnt8, k / 8);
            end
        end
        check("w4_bin", bin8, 1);

        // Random counter-like traffic with occasional corrupted samples.
        reset_dut();
        c_pos = 0;
        c_ovf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_rst = ($urandom_range(0, 31) == 0);
            r_clr = ($urandom_range(0, 7) == 0);
            r_g   = seq_at(c_pos);
            r_ovf = c_ovf;
            if ($urandom_range(0, 39) == 0) r_g = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) r_ovf = !r_ovf;
            drive(r_rst, r_en, r_g, r_ovf, r_clr);
            check_all($sformatf("rnd%0d", n));
            if (r_rst) begin
                c_pos = 0;
                c_ovf = 1'b0;
            end else if (r_en) begin
                if (c_pos == 7) c_ovf = 1'b1;
                c_pos = (c_pos + 1) % 8;
            end
        end

        reset_dut();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
